// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - stage/source indices and default hazard masks for the pipeline arbiter
package pipeline_ctrl_pkg;

    localparam int STG_PC     = 0;
    localparam int STG_PRE_IF = 1;
    localparam int STG_IF_ID  = 2;
    localparam int STG_ID_EX  = 3;
    localparam int STG_EX_MEM = 4;
    localparam int STG_MEM_WB = 5;

    localparam int SRC_COMPRESS   = 0;
    localparam int SRC_LOAD_USE   = 1;
    localparam int SRC_MUL_DIV    = 2;
    localparam int SRC_JUMP       = 3;
    localparam int SRC_TRAP_CSR   = 4;
    localparam int SRC_TRAP_ECALL = 5;
    localparam int SRC_RAM_IF     = 6;
    localparam int SRC_RAM_MEM    = 7;

    // Packed with source 7 in the top slice, source 0 in the bottom slice.
    localparam logic [47:0] DEF_STALL_MASKS = {6'h1F, 6'h1D, 6'h02, 6'h3F, 6'h03, 6'h07, 6'h07, 6'h02};
    localparam logic [47:0] DEF_FLUSH_MASKS = {6'h20, 6'h00, 6'h0E, 6'h0E, 6'h0E, 6'h10, 6'h08, 6'h02};
    localparam logic [23:0] DEF_SRC_STAGE   = {3'd4, 3'd1, 3'd5, 3'd5, 3'd3, 3'd3, 3'd2, 3'd1};
    localparam logic [7:0]  DEF_PULSE_MASK  = 8'h28;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/hazard_prio_enc.sv
// rtl/hazard_prio_enc.sv - highest-index-wins priority encoder returning winner index and valid
module hazard_prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipeline_hazard_arbiter.sv
// rtl/pipeline_hazard_arbiter.sv - parametrised stall/flush arbiter with init flush, pulse latching, watchdog and counters
module pipeline_hazard_arbiter
    import pipeline_ctrl_pkg::*;
#(
    parameter int                                NUM_STAGES         = 6,
    parameter int                                NUM_REQ            = 8,
    parameter logic [NUM_REQ*NUM_STAGES-1:0]     STALL_MASKS        = DEF_STALL_MASKS,
    parameter logic [NUM_REQ*NUM_STAGES-1:0]     FLUSH_MASKS        = DEF_FLUSH_MASKS,
    parameter logic [NUM_REQ-1:0]                PULSE_MASK         = DEF_PULSE_MASK,
    parameter logic [NUM_REQ*3-1:0]              SRC_STAGE          = DEF_SRC_STAGE,
    parameter int                                RESET_FLUSH_CYCLES = 4,
    parameter int                                WDOG_LIMIT         = 1024,
    parameter int                                CNT_W              = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_STAGES-1:0]      stall_o,
    output logic [NUM_STAGES-1:0]      flush_o,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [NUM_REQ-1:0]         pend_o,
    output logic                       busy_o,
    output logic                       deadlock_o,
    input  logic                       deadlock_clr_i,
    input  logic [$clog2(NUM_REQ)-1:0] cnt_sel_i,
    output logic [CNT_W-1:0]           cnt_o,
    input  logic                       cnt_clr_i
);

    localparam int SEL_W  = $clog2(NUM_REQ);
    localparam int INIT_W = $clog2(RESET_FLUSH_CYCLES) + 1;
    localparam int WD_W   = $clog2(WDOG_LIMIT + 1);

    logic [0:0]            state;
    logic [INIT_W-1:0]     init_cnt;
    logic [NUM_REQ-1:0]    pend;
    logic [NUM_REQ-1:0]    pend_nxt;
    logic [NUM_REQ-1:0]    eff;
    logic [SEL_W-1:0]      win_idx;
    logic                  win_valid;
    logic [NUM_STAGES-1:0] win_stall;
    logic [NUM_STAGES-1:0] win_flush;
    logic [7:0]            flush_pad;
    logic                  run;
    logic [WD_W-1:0]       wd_cnt;
    logic [CNT_W-1:0]      cnt [NUM_REQ];

    assign run = (state == ST_RUN);
    // Requests are masked off while flushing after reset, so nothing wins or latches.
    assign eff = run ? (req_i | pend) : '0;

    hazard_prio_enc #(
        .N     (NUM_REQ),
        .IDX_W (SEL_W)
    ) u_prio (
        .req   (eff),
        .idx   (win_idx),
        .valid (win_valid)
    );

    always_comb begin
        win_stall = '0;
        win_flush = '0;
        if (win_valid) begin
            win_stall = STALL_MASKS[win_idx*NUM_STAGES +: NUM_STAGES];
            win_flush = FLUSH_MASKS[win_idx*NUM_STAGES +: NUM_STAGES];
        end
    end

    assign flush_pad  = 8'(win_flush);
    assign stall_o    = win_stall;
    assign flush_o    = run ? win_flush : '1;
    assign grant_o    = win_valid ? (NUM_REQ'(1) << win_idx) : '0;
    assign pend_o     = pend;
    assign busy_o     = ~run;
    assign cnt_o      = cnt[cnt_sel_i];

    // A latched pulse dies with its instruction when the winner flushes that stage.
    always_comb begin
        logic [2:0] stg;
        stg      = '0;
        pend_nxt = pend;
        for (int j = 0; j < NUM_REQ; j++) begin
            stg = SRC_STAGE[j*3 +: 3];
            if (win_valid && (win_idx == SEL_W'(j))) begin
                pend_nxt[j] = 1'b0;
            end else if (flush_pad[stg]) begin
                pend_nxt[j] = 1'b0;
            end else if (req_i[j] && PULSE_MASK[j]) begin
                pend_nxt[j] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            init_cnt <= INIT_W'(RESET_FLUSH_CYCLES - 1);
            pend     <= '0;
        end else if (!run) begin
            if (init_cnt == '0) begin
                state <= ST_RUN;
            end else begin
                init_cnt <= init_cnt - 1'b1;
            end
        end else begin
            pend <= pend_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || deadlock_clr_i) begin
            wd_cnt     <= '0;
            deadlock_o <= 1'b0;
        end else if (|win_stall) begin
            if (wd_cnt != WD_W'(WDOG_LIMIT)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_cnt >= WD_W'(WDOG_LIMIT - 1)) begin
                deadlock_o <= 1'b1;
            end
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!rst_n || cnt_clr_i) begin
                cnt[i] <= '0;
            end else if (grant_o[i] && (|win_stall) && (cnt[i] != '1)) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_arbiter.sv
// tb/tb_pipeline_hazard_arbiter.sv - self-checking bench with a behavioural arbiter model and directed vectors
module tb_pipeline_hazard_arbiter;

    localparam int LIMIT = 1024;
    localparam longint CMAX = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = '0;
    logic        dl_clr = 1'b0;
    logic [2:0]  cnt_sel = '0;
    logic        cnt_clr = 1'b0;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic [7:0]  grant;
    logic [7:0]  pend;
    logic        busy;
    logic        deadlock;
    logic [31:0] cnt_val;

    int checks = 0;
    int failures = 0;

    int stall_tab [8] = '{'h02, 'h07, 'h07, 'h03, 'h3F, 'h02, 'h1D, 'h1F};
    int flush_tab [8] = '{'h02, 'h08, 'h10, 'h0E, 'h0E, 'h0E, 'h00, 'h20};
    int src_stage [8] = '{1, 2, 3, 3, 5, 5, 1, 4};
    bit is_pulse  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};

    bit     m_valid = 0;
    bit     m_run = 0;
    int     m_init_left = 0;
    bit     m_pend [8];
    int     m_wd = 0;
    bit     m_dl = 0;
    longint m_cnt [8];

    pipeline_hazard_arbiter #(
        .RESET_FLUSH_CYCLES (4),
        .WDOG_LIMIT         (LIMIT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_i          (req),
        .stall_o        (stall),
        .flush_o        (flush),
        .grant_o        (grant),
        .pend_o         (pend),
        .busy_o         (busy),
        .deadlock_o     (deadlock),
        .deadlock_clr_i (dl_clr),
        .cnt_sel_i      (cnt_sel),
        .cnt_o          (cnt_val),
        .cnt_clr_i      (cnt_clr)
    );

    always #5 clk = ~clk;

    function automatic int model_winner();
        for (int i = 7; i >= 0; i--) begin
            if (req[i] || m_pend[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model advance: takes what the arbiter must do this cycle and applies it at the edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid     = 1;
            m_run       = 0;
            m_init_left = 3;
            m_wd        = 0;
            m_dl        = 0;
            for (int i = 0; i < 8; i++) begin
                m_pend[i] = 0;
                m_cnt[i]  = 0;
            end
        end else if (m_valid) begin
            int w;
            int sm;
            int fm;
            w  = m_run ? model_winner() : -1;
            sm = (w >= 0) ? stall_tab[w] : 0;
            fm = (w >= 0) ? flush_tab[w] : 0;
            if (m_run) begin
                for (int j = 0; j < 8; j++) begin
                    if (j == w) m_pend[j] = 0;
                    else if (((fm >> src_stage[j]) & 1) != 0) m_pend[j] = 0;
                    else if (req[j] && is_pulse[j]) m_pend[j] = 1;
                end
            end
            if (cnt_clr) begin
                for (int i = 0; i < 8; i++) m_cnt[i] = 0;
            end else if (w >= 0 && sm != 0 && m_cnt[w] < CMAX) begin
                m_cnt[w]++;
            end
            if (dl_clr) begin
                m_wd = 0;
                m_dl = 0;
            end else if (sm != 0) begin
                if (m_wd < LIMIT) m_wd++;
                if (m_wd >= LIMIT) m_dl = 1;
            end else begin
                m_wd = 0;
            end
            if (!m_run) begin
                if (m_init_left == 0) m_run = 1;
                else m_init_left--;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            int w;
            int exp_pend;
            w = m_run ? model_winner() : -1;
            exp_pend = 0;
            for (int j = 0; j < 8; j++) exp_pend |= int'(m_pend[j]) << j;
            chk("stall", stall, (w >= 0) ? stall_tab[w] : 0);
            chk("flush", flush, !m_run ? 'h3F : ((w >= 0) ? flush_tab[w] : 0));
            chk("grant", grant, (w >= 0) ? (1 << w) : 0);
            chk("pend", pend, exp_pend);
            chk("busy", busy, !m_run);
            chk("deadlock", deadlock, m_dl);
            chk("cnt_o", cnt_val, m_cnt[cnt_sel]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("init_busy", busy, 1);
            chk("init_flush", flush, 'h3F);
            cyc();
        end
        #1;
        chk("run_busy", busy, 0);
        chk("run_flush_idle", flush, 0);

        cyc();
        req = 8'h88;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("ram_mem_stall", stall, 'h1F);
            chk("ram_mem_flush", flush, 'h20);
            cyc();
        end
        req = 8'h00;
        #1;
        chk("jump_pend", pend, 'h08);
        chk("jump_stall", stall, 'h03);
        chk("jump_flush", flush, 'h0E);
        cyc();
        #1;
        chk("jump_pend_clr", pend, 0);

        cyc();
        req = 8'h28;
        #1;
        chk("ecall_stall", stall, 'h02);
        chk("ecall_flush", flush, 'h0E);
        chk("ecall_grant", grant, 'h20);
        cyc();
        req = 8'h00;
        #1;
        chk("ecall_jump_killed", pend, 0);

        cyc();
        req = 8'h04;
        repeat (LIMIT - 1) cyc();
        chk("wdog_before", deadlock, 0);
        cyc();
        chk("wdog_set", deadlock, 1);
        repeat (1100 - LIMIT) cyc();
        chk("wdog_sticky", deadlock, 1);
        dl_clr = 1'b1;
        cyc();
        dl_clr = 1'b0;
        #1;
        chk("wdog_clr", deadlock, 0);
        req = 8'h00;
        cyc();

        cnt_sel = 3'd1;
        req = 8'h02;
        repeat (10) cyc();
        req = 8'h00;
        #1;
        chk("cnt_load_use", cnt_val, 10);
        cyc();
        req = 8'h02;
        cnt_clr = 1'b1;
        cyc();
        cnt_clr = 1'b0;
        #1;
        chk("cnt_clr", cnt_val, 0);
        req = 8'h00;
        cyc();

        req = 8'h88;
        cyc();
        req = 8'h80;
        #1;
        chk("pend_before_rst", pend, 'h08);
        rst_n = 1'b0;
        cyc();
        #1;
        chk("rst_pend", pend, 0);
        chk("rst_flush", flush, 'h3F);
        chk("rst_stall", stall, 0);
        rst_n = 1'b1;
        req = 8'h00;
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_arbiter.md
Name: pipeline_hazard_arbiter

Overview:
- Parametrised stall/flush arbiter for the in-order pipeline. Generalises the fixed pipeline controller to NUM_STAGES stages and NUM_REQ hazard sources, with per-source masks set by parameters.
- Adds behaviour the fixed controller lacks:
  - a post-reset flush sequence;
  - latching of pulse-type requests (jump, ecall) that lose arbitration;
  - a stall watchdog;
  - per-source stall-cycle counters.
- Sits between the hazard sources (IF/ID/EX/MEM/WB) and the stage registers.

Parameters:
- NUM_STAGES, 6, stage count. Bit map: 0=PC, 1=Pre_IF, 2=IF_ID, 3=ID_EX, 4=EX_MEM, 5=MEM_WB.
- NUM_REQ, 8, hazard sources. A higher index means higher priority.
- STALL_MASKS, pkg default, NUM_REQ*NUM_STAGES bits. Source i uses bits [i*NUM_STAGES +: NUM_STAGES].
- FLUSH_MASKS, pkg default, same packing as STALL_MASKS.
- PULSE_MASK, 8'h28, NUM_REQ bits. 1 = the source is latched as pending if it loses arbitration.
- SRC_STAGE, pkg default, NUM_REQ*3 bits. Stage index of the instruction that raised each source.
- RESET_FLUSH_CYCLES, 4, cycles of full flush after reset release (>=1).
- WDOG_LIMIT, 1024, cycles of continuous nonzero stall before deadlock_o is raised.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_i  in  NUM_REQ  level hazard requests
- stall_o  out  NUM_STAGES  per-stage stall
- flush_o  out  NUM_STAGES  per-stage flush
- grant_o  out  NUM_REQ  one-hot winning source (0 if none)
- pend_o  out  NUM_REQ  pending pulse-request latches
- busy_o  out  1  high while in INIT
- deadlock_o  out  1  sticky watchdog flag
- deadlock_clr_i  in  1  clears deadlock_o and the watchdog counter
- cnt_sel_i  in  $clog2(NUM_REQ)  counter readout select
- cnt_o  out  CNT_W  selected counter value (combinational read)
- cnt_clr_i  in  1  zeroes all counters

Behaviour:
- Reset: sampled on the clk edge while rst_n=0.
  - While rst_n=0: stall_o=0, flush_o=all ones, grant_o=0, pend_o=0, deadlock_o=0, all counters=0, state=INIT with init counter=RESET_FLUSH_CYCLES-1.
  - A reset asserted mid-operation discards pending latches and counters immediately at that edge.
- FSM INIT:
  - Outputs: flush_o=all ones, stall_o=0, grant_o=0, busy_o=1.
  - The counter decrements each cycle; INIT->RUN when it reaches 0. INIT therefore lasts exactly RESET_FLUSH_CYCLES cycles after rst_n rises.
  - req_i is ignored and not latched.
- FSM RUN:
  - eff = req_i | pend.
  - Winner w = highest set index of eff.
  - stall_o = STALL_MASKS[w] and flush_o = FLUSH_MASKS[w], combinationally in the same cycle (0-cycle latency).
  - If eff=0, both outputs are 0.
- Pending update, every RUN edge, for each j != w:
  - Set pend[j] if req_i[j] & PULSE_MASK[j].
  - Clear pend[j] instead if FLUSH_MASKS[w] bit SRC_STAGE[j] is 1, because the originating instruction is killed. Clear takes priority over set.
- Pending update for the winner: pend[w] clears at the edge ending its grant cycle. A pending request wins for exactly one cycle.
- Non-pulse sources are never latched; they must stay asserted until served.
- Watchdog:
  - Counts consecutive RUN cycles with stall_o != 0; resets to 0 on any cycle with stall_o == 0.
  - When the count reaches WDOG_LIMIT, deadlock_o is set and held until deadlock_clr_i or reset; the count saturates.
  - If deadlock_clr_i and the set condition occur in the same cycle, clear wins.
- Counters: cnt[i] increments on each RUN cycle where grant_o[i]=1 and STALL_MASKS[i] != 0. Counters saturate at all ones. cnt_clr_i takes priority over increment.
- grant_o, stall_o and flush_o are purely a function of req_i, pend and state. There is no combinational path from cnt_sel_i to them.

Decomposition:
- Package pipeline_ctrl_pkg holds:
  - stage index constants;
  - source index constants: 0 compress, 1 load_use, 2 mul_div, 3 jump, 4 trap_csr, 5 trap_ecall, 6 ram_if, 7 ram_mem;
  - default masks in hex, one per source 0..7:
    - stall 02, 07, 07, 03, 3F, 02, 1D, 1F;
    - flush 02, 08, 10, 0E, 0E, 0E, 00, 20;
  - SRC_STAGE default {4,1,5,5,3,3,2,1} listed for sources 7..0.
- One sub-module, hazard_prio_enc: parametrised highest-index one-hot encoder that returns the winner index and a valid flag.

Test Plan:
- Reset then release with RESET_FLUSH_CYCLES=4 -> flush_o=3F and busy_o=1 for exactly 4 cycles, then flush_o=00 with req_i=0.
- req_i=0x80 (ram_mem) and 0x08 (jump) together for 3 cycles, then 0x00 -> stall 1F / flush 20 for 3 cycles, pend_o=0x08, then one cycle of stall 03 / flush 0E, then pend_o=0.
- req_i=0x28 (ecall + jump) for 1 cycle -> ecall wins (stall 02, flush 0E). Jump's SRC_STAGE 3 is flushed, so pend_o stays 0.
- req_i=0x04 held for 1100 cycles with WDOG_LIMIT=1024 -> deadlock_o rises at cycle 1024. Pulse deadlock_clr_i -> deadlock_o falls next cycle.
- Grant load_use (0x02) for 10 cycles, cnt_sel_i=1 -> cnt_o=10. Assert cnt_clr_i together with req -> cnt_o=0.
- Assert rst_n=0 while pend_o=0x08 -> the next cycle shows pend_o=0, flush_o=3F, stall_o=0.
